// File: rtl/dual_priority_arbiter_pkg.sv
// Shared types, constants and helpers for the dual priority arbiter.
package dual_priority_pkg;

  localparam int DPA_DEFAULT_N = 12;

  // Widest request vector the one-hot helper can produce; callers size-cast down to N.
  localparam int DPA_MAX_N = 64;

  localparam logic DPA_MODE_FIXED = 1'b0;
  localparam logic DPA_MODE_RR    = 1'b1;

  // Output register occupancy.
  typedef enum logic {
    DPA_EMPTY = 1'b0,
    DPA_FULL  = 1'b1
  } dpa_state_e;

  // One-hot decode of a bit index; an out-of-range index yields all zeros.
  function automatic logic [DPA_MAX_N-1:0] idx2onehot(input int idx);
    logic [DPA_MAX_N-1:0] one;
    one = {{(DPA_MAX_N-1){1'b0}}, 1'b1};
    return (idx < 0) ? '0 : (one << idx);
  endfunction

endpackage

// File: rtl/dual_priority_arbiter_if.sv
// Request/result handshake bundle for the dual priority arbiter.
// master = request producer / result consumer, slave = the arbiter.
interface dual_priority_arbiter_if
  import dual_priority_pkg::*;
#(
  parameter int N = DPA_DEFAULT_N
);
  localparam int IDXW = $clog2(N);

  // Request side
  logic            rr_mode;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    req;

  // Result side
  logic            out_valid;
  logic            out_ready;
  logic            first_vld;
  logic [IDXW-1:0] first_idx;
  logic [N-1:0]    first_oh;
  logic            second_vld;
  logic [IDXW-1:0] second_idx;
  logic [N-1:0]    second_oh;

  modport master (
    output rr_mode, in_valid, req, out_ready,
    input  in_ready, out_valid, first_vld, first_idx, first_oh,
           second_vld, second_idx, second_oh
  );

  modport slave (
    input  rr_mode, in_valid, req, out_ready,
    output in_ready, out_valid, first_vld, first_idx, first_oh,
           second_vld, second_idx, second_oh
  );

endinterface

// File: rtl/dual_priority_arbiter_find.sv
// Rotating priority search: the first set bit of req_i scanning
// start_i, start_i+1, ..., N-1, 0, ..., start_i-1. Purely combinational.
module rot_priority_find #(
  parameter  int N    = 12,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] start_i,
  output logic [IDXW-1:0] idx_o,
  output logic            vld_o
);

  // Rotate so the start position lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    int           s;
    int           hit;
    int           pos;
    logic [N-1:0] rot;
    s     = int'(start_i);
    if (s >= N) s = 0;
    rot   = (req_i >> s) | (req_i << (N - s));
    hit   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) hit = k;
    end
    pos   = s + hit;
    if (pos >= N) pos = pos - N;
    vld_o = |req_i;
    idx_o = vld_o ? IDXW'(pos) : '0;
  end

endmodule

// File: rtl/dual_priority_arbiter.sv
// Registered dual priority arbiter: finds the highest and second-highest
// priority requests (fixed or round-robin order) and returns them through a
// one-entry, bubble-free output register.
// Optional statistics counters: define DUAL_PRIORITY_ARBITER_STATS_EN.
module dual_priority_arbiter
  import dual_priority_pkg::*;
#(
  parameter  int N    = DPA_DEFAULT_N,
  localparam int IDXW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  dual_priority_arbiter_if.slave bus_if
`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
  ,
  output logic [15:0]            stat_xact_o,
  output logic [15:0]            stat_conflict_o
`endif
);

  dpa_state_e      state_q;
  logic [IDXW-1:0] ptr_q;
  logic            first_vld_q,  second_vld_q;
  logic [IDXW-1:0] first_idx_q,  second_idx_q;
  logic [N-1:0]    first_oh_q,   second_oh_q;

  logic            accept;
  logic [IDXW-1:0] start_d;
  logic [IDXW-1:0] ptr_d;
  logic            first_vld_d,  second_vld_d;
  logic [IDXW-1:0] first_idx_d,  second_idx_d;
  logic [N-1:0]    first_oh_d,   second_oh_d;
  logic [N-1:0]    first_sel;
  logic [N-1:0]    second_sel;
  logic [N-1:0]    masked_req;

  // Ready whenever the register is empty or is being drained this cycle.
  assign bus_if.in_ready = (state_q == DPA_EMPTY) || bus_if.out_ready;
  assign accept          = bus_if.in_valid && bus_if.in_ready;

  assign start_d = (bus_if.rr_mode == DPA_MODE_RR) ? ptr_q : '0;

  rot_priority_find #(.N(N)) u_first (
    .req_i   (bus_if.req),
    .start_i (start_d),
    .idx_o   (first_idx_d),
    .vld_o   (first_vld_d)
  );

  // Scanning from the same start with the winner removed yields the runner-up.
  assign first_sel  = N'(idx2onehot(int'(first_idx_d)));
  assign masked_req = bus_if.req & ~first_sel;

  rot_priority_find #(.N(N)) u_second (
    .req_i   (masked_req),
    .start_i (start_d),
    .idx_o   (second_idx_d),
    .vld_o   (second_vld_d)
  );

  assign second_sel  = N'(idx2onehot(int'(second_idx_d)));
  assign first_oh_d  = first_vld_d  ? first_sel  : '0;
  assign second_oh_d = second_vld_d ? second_sel : '0;

  // Round-robin pointer moves to just past the winner, wrapping at N-1.
  assign ptr_d = (first_idx_d == IDXW'(N - 1)) ? '0 : first_idx_d + 1'b1;

  // Output register FSM with registered results and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: only control and result registers are reset; there is no storage array here.
      state_q      <= DPA_EMPTY;
      ptr_q        <= '0;
      first_vld_q  <= 1'b0;
      first_idx_q  <= '0;
      first_oh_q   <= '0;
      second_vld_q <= 1'b0;
      second_idx_q <= '0;
      second_oh_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        DPA_EMPTY: if (accept) state_q <= DPA_FULL;
        DPA_FULL:  if (bus_if.out_ready && !accept) state_q <= DPA_EMPTY;
        default:   state_q <= DPA_EMPTY;
      endcase
      if (accept) begin
        first_vld_q  <= first_vld_d;
        first_idx_q  <= first_idx_d;
        first_oh_q   <= first_oh_d;
        second_vld_q <= second_vld_d;
        second_idx_q <= second_idx_d;
        second_oh_q  <= second_oh_d;
        if ((bus_if.rr_mode == DPA_MODE_RR) && first_vld_d) ptr_q <= ptr_d;
      end
    end
  end

  assign bus_if.out_valid  = (state_q == DPA_FULL);
  assign bus_if.first_vld  = first_vld_q;
  assign bus_if.first_idx  = first_idx_q;
  assign bus_if.first_oh   = first_oh_q;
  assign bus_if.second_vld = second_vld_q;
  assign bus_if.second_idx = second_idx_q;
  assign bus_if.second_oh  = second_oh_q;

`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
  logic [15:0] stat_xact_q;
  logic [15:0] stat_conflict_q;

  // Transaction counter wraps; conflict counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_xact_q     <= '0;
      stat_conflict_q <= '0;
    end else if (accept) begin
      stat_xact_q <= stat_xact_q + 16'd1;
      if (second_vld_d && (stat_conflict_q != 16'hFFFF)) begin
        stat_conflict_q <= stat_conflict_q + 16'd1;
      end
    end
  end

  assign stat_xact_o     = stat_xact_q;
  assign stat_conflict_o = stat_conflict_q;
`endif

endmodule

// File: tb/tb_dual_priority_arbiter.sv
// Directed testbench for dual_priority_arbiter (N=12): reset, fixed and
// round-robin search, pointer wrap, backpressure with scoreboard, optional stats.
module tb_dual_priority_arbiter;
  import dual_priority_pkg::*;

  typedef struct {
    logic       fv;
    logic [3:0] fi;
    logic       sv;
    logic [3:0] si;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dual_priority_arbiter_if #(.N(12)) bus ();

`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
  logic [15:0] stat_xact;
  logic [15:0] stat_conflict;
`endif

  dual_priority_arbiter #(.N(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
    ,
    .stat_xact_o     (stat_xact),
    .stat_conflict_o (stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] oh(input logic v, input logic [3:0] i);
    logic [11:0] one;
    one = 12'h001;
    return v ? (one << i) : 12'h000;
  endfunction

  task automatic check_res(input string tag, input logic fv, input logic [3:0] fi,
                           input logic sv, input logic [3:0] si);
    check({tag, ".ov"},  32'(bus.out_valid),  32'(1'b1));
    check({tag, ".fv"},  32'(bus.first_vld),  32'(fv));
    check({tag, ".fi"},  32'(bus.first_idx),  32'(fi));
    check({tag, ".foh"}, 32'(bus.first_oh),   32'(oh(fv, fi)));
    check({tag, ".sv"},  32'(bus.second_vld), 32'(sv));
    check({tag, ".si"},  32'(bus.second_idx), 32'(si));
    check({tag, ".soh"}, 32'(bus.second_oh),  32'(oh(sv, si)));
  endtask

  // One accepted transaction with the consumer ready; sampled 1 time unit after the edge.
  task automatic send(input logic [11:0] r, input logic rr);
    bus.req       = r;
    bus.rr_mode   = rr;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    logic [11:0] sreq [8];
    exp_t        tbl  [8];
    exp_t        q    [$];
    exp_t        e;
    int          consumed;

    vectors     = 0;
    miscompares = 0;
    consumed    = 0;
    rst         = 1'b1;
    bus.req       = '0;
    bus.rr_mode   = DPA_MODE_FIXED;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst.ov",  32'(bus.out_valid), 32'(1'b0));
    check("rst.ir",  32'(bus.in_ready),  32'(1'b1));
    check("rst.fv",  32'(bus.first_vld), 32'(1'b0));
    check("rst.foh", 32'(bus.first_oh),  32'(12'h000));
    check("rst.soh", 32'(bus.second_oh), 32'(12'h000));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fixed priority
    send(12'h000, DPA_MODE_FIXED); check_res("fx000", 1'b0, 4'd0,  1'b0, 4'd0);
    send(12'h024, DPA_MODE_FIXED); check_res("fx024", 1'b1, 4'd2,  1'b1, 4'd5);
    check("fx024.foh_lit", 32'(bus.first_oh),  32'(12'h004));
    check("fx024.soh_lit", 32'(bus.second_oh), 32'(12'h020));
    send(12'h800, DPA_MODE_FIXED); check_res("fx800", 1'b1, 4'd11, 1'b0, 4'd0);
    send(12'hFFF, DPA_MODE_FIXED); check_res("fxFFF", 1'b1, 4'd0,  1'b1, 4'd1);
    send(12'h0A0, DPA_MODE_FIXED); check_res("fx0A0", 1'b1, 4'd5,  1'b1, 4'd7);

    // Round-robin, all requests set: winner walks 0..11 then wraps to 0
    for (int i = 0; i < 13; i++) begin
      send(12'hFFF, DPA_MODE_RR);
      check_res("rrFFF", 1'b1, 4'(i % 12), 1'b1, 4'((i + 1) % 12));
    end
    // ptr=1: single request at bit 9 moves ptr to 10
    send(12'h200, DPA_MODE_RR); check_res("rr200", 1'b1, 4'd9, 1'b0, 4'd0);
    // ptr=10: scan 10,11,0,1 -> first 0, second 1, ptr becomes 1
    send(12'h003, DPA_MODE_RR); check_res("rrwrap", 1'b1, 4'd0, 1'b1, 4'd1);
    send(12'hFFF, DPA_MODE_RR); check_res("rrptr1", 1'b1, 4'd1, 1'b1, 4'd2);
    // Fixed mode ignores and holds ptr=2
    send(12'hFFF, DPA_MODE_FIXED); check_res("fxhold", 1'b1, 4'd0, 1'b1, 4'd1);
    send(12'hFFF, DPA_MODE_RR);    check_res("rrptr2", 1'b1, 4'd2, 1'b1, 4'd3);
    // Empty request holds ptr=3
    send(12'h000, DPA_MODE_RR);    check_res("rr000",  1'b0, 4'd0, 1'b0, 4'd0);
    send(12'hFFF, DPA_MODE_RR);    check_res("rrptr3", 1'b1, 4'd3, 1'b1, 4'd4);

    // Backpressure and streaming (fixed mode)
    sreq[0] = 12'h024; tbl[0] = '{1'b1, 4'd2,  1'b1, 4'd5};
    sreq[1] = 12'h800; tbl[1] = '{1'b1, 4'd11, 1'b0, 4'd0};
    sreq[2] = 12'h001; tbl[2] = '{1'b1, 4'd0,  1'b0, 4'd0};
    sreq[3] = 12'h0C0; tbl[3] = '{1'b1, 4'd6,  1'b1, 4'd7};
    sreq[4] = 12'h400; tbl[4] = '{1'b1, 4'd10, 1'b0, 4'd0};
    sreq[5] = 12'h000; tbl[5] = '{1'b0, 4'd0,  1'b0, 4'd0};
    sreq[6] = 12'h999; tbl[6] = '{1'b1, 4'd0,  1'b1, 4'd3};
    sreq[7] = 12'h810; tbl[7] = '{1'b1, 4'd4,  1'b1, 4'd11};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.drain_ov", 32'(bus.out_valid), 32'(1'b0));

    bus.out_ready = 1'b0;
    bus.rr_mode   = DPA_MODE_FIXED;
    bus.req       = sreq[0];
    bus.in_valid  = 1'b1;
    #1;
    check("bp.empty_ir", 32'(bus.in_ready), 32'(1'b1));
    @(posedge clk);
    #1;
    q.push_back(tbl[0]);
    bus.req = sreq[1];
    for (int c = 0; c < 5; c++) begin
      check("bp.stall_ir", 32'(bus.in_ready),   32'(1'b0));
      check("bp.stall_ov", 32'(bus.out_valid),  32'(1'b1));
      check("bp.stall_fi", 32'(bus.first_idx),  32'(4'd2));
      check("bp.stall_si", 32'(bus.second_idx), 32'(4'd5));
      @(posedge clk);
      #1;
    end

    for (int i = 1; i < 8; i++) begin
      bus.req       = sreq[i];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && (q.size() > 0)) begin
        e = q.pop_front();
        check("sb.fv",  32'(bus.first_vld),  32'(e.fv));
        check("sb.fi",  32'(bus.first_idx),  32'(e.fi));
        check("sb.foh", 32'(bus.first_oh),   32'(oh(e.fv, e.fi)));
        check("sb.sv",  32'(bus.second_vld), 32'(e.sv));
        check("sb.si",  32'(bus.second_idx), 32'(e.si));
        consumed++;
      end else if (bus.out_valid) begin
        consumed++;
      end
      check("sb.ir", 32'(bus.in_ready), 32'(1'b1));
      if (bus.in_ready) q.push_back(tbl[i]);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.out_valid && (q.size() > 0)) begin
        e = q.pop_front();
        check("sb.fv",  32'(bus.first_vld),  32'(e.fv));
        check("sb.fi",  32'(bus.first_idx),  32'(e.fi));
        check("sb.sv",  32'(bus.second_vld), 32'(e.sv));
        check("sb.si",  32'(bus.second_idx), 32'(e.si));
        consumed++;
      end else if (bus.out_valid) begin
        consumed++;
      end
      @(posedge clk);
      #1;
    end
    check("sb.consumed", 32'(consumed), 32'(8));
    check("sb.qempty",   32'(q.size()), 32'(0));
    check("sb.idle_ov",  32'(bus.out_valid), 32'(1'b0));

    // Reset mid-transaction with a result held and ptr moved to 5
    send(12'h010, DPA_MODE_RR); check_res("pre_rst", 1'b1, 4'd4, 1'b0, 4'd0);
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.ov",  32'(bus.out_valid), 32'(1'b0));
    check("arst.fv",  32'(bus.first_vld), 32'(1'b0));
    check("arst.fi",  32'(bus.first_idx), 32'(4'd0));
    check("arst.foh", 32'(bus.first_oh),  32'(12'h000));
    check("arst.sv",  32'(bus.second_vld), 32'(1'b0));
    check("arst.soh", 32'(bus.second_oh), 32'(12'h000));
    check("arst.ir",  32'(bus.in_ready),  32'(1'b1));
`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
    check("arst.sx", 32'(stat_xact),     32'(0));
    check("arst.sc", 32'(stat_conflict), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(12'hFFF, DPA_MODE_RR); check_res("post_rst", 1'b1, 4'd0, 1'b1, 4'd1);

`ifdef DUAL_PRIORITY_ARBITER_STATS_EN
    // 1 accept so far (a conflict); 19 more of which 6 carry two requests
    for (int i = 0; i < 19; i++) begin
      if (i < 6)           send(12'h003, DPA_MODE_FIXED);
      else if (i % 2 != 0) send(12'h000, DPA_MODE_FIXED);
      else                 send(12'h100, DPA_MODE_FIXED);
    end
    check("stat.xact",     32'(stat_xact),     32'(20));
    check("stat.conflict", 32'(stat_conflict), 32'(7));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
